pkt_encoder: RTL and testbench
==============================

# pkt_encoder

Parametrised packet framer for the upstream link. Arbitrates round-robin among `N_SRC` message sources and serialises one packet at a time onto a byte-wide valid/ready transmit stream. Each packet is PREFIX, source id, length, payload, check byte. It sits between the per-source show-ahead message FIFOs and the UART/USB transmitter.

## Interface

Parameters:
- `N_SRC`, default 38: number of sources; legal range 1..256.
- `SRC_W`, default `$clog2(N_SRC)` (minimum 1): width of the internal source index.
- `PREFIX`, default 8'hA5: first byte of every packet.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`, input, 1: sole clock.
- `rst`, input, 1: synchronous, active-high reset.
- `src_valid`, input, N_SRC: bit i high means source i holds a complete message.
- `src_len`, input, 8*N_SRC: payload length of source i at bits [8i+:8], range 0..255. Stable while `src_valid[i]` is high.
- `src_data`, input, 8*N_SRC: show-ahead FIFO head of source i at bits [8i+:8].
- `src_rdreq`, output, N_SRC: one-hot pop strobe, combinational.
- `tx_data`, output, 8: transmit byte, registered.
- `tx_valid`, output, 1: `tx_data` is valid.
- `tx_last`, output, 1: current byte is the check byte.
- `tx_ready`, input, 1: sink accepts the byte when `tx_valid` and `tx_ready` are both high.
- `busy`, output, 1: high in every state other than IDLE.
- `cur_src`, output, 8: zero-extended index of the granted source.

## Operation

State machine states: IDLE, PREFIX, SRC, LEN, DATA, CHK.

IDLE
- The grant is the first `src_valid` bit at or above `rr_ptr`, searching cyclically.
- If any bit is set: latch grant g and `len_q = src_len[g]`. Load `tx_data = PREFIX`, set `tx_valid = 1`, go to PREFIX.

Byte states
- Each byte state holds its byte until it is accepted. On acceptance the next byte is loaded the same edge:
  - PREFIX goes to SRC; load g.
  - SRC goes to LEN; load `len_q`.
  - LEN goes to DATA, loading `src_data[g]`. If `len_q == 0`, it goes to CHK instead, loading the check byte.
  - DATA: byte counter `cnt`, 8 bits, counts loaded payload bytes. While `cnt < len_q`, load the next `src_data[g]`. Otherwise go to CHK and load the check byte.
  - CHK asserts `tx_last`. On acceptance: `tx_valid = 0`, `rr_ptr = (g+1) mod N_SRC`, `cnt = 0`, go to IDLE.
- `src_rdreq[g]` is high exactly in cycles where `tx_data` loads from `src_data[g]`. The FIFO pops on that same edge, so there are `len_q` pops per packet and no pops for zero length.

Check byte
- Mod-256 sum of the source byte, the length byte and all payload bytes. Accumulation is 8-bit and wraps; carries are discarded.

Other rules
- `tx_data`/`tx_valid`/`tx_last` change only when `tx_valid` is low or on acceptance. The block never withdraws `tx_valid`.
- `src_valid` of a source dropping mid-packet is ignored; the packet completes. Sources are not sampled outside IDLE.
- With `N_SRC = 1`, the grant is always 0 and `rr_ptr` stays 0.

## Timing

- Reset values: `tx_data = 0`, `tx_valid = 0`, `tx_last = 0`, `src_rdreq = 0`, `busy = 0`, `cur_src = 0`. Internally `rr_ptr = 0`, `cnt = 0`, state IDLE.
- Reset mid-packet abandons the packet; outputs take reset values at the next edge. No partial FIFO draining occurs afterwards.
- If `src_valid` is high in IDLE at edge t, PREFIX is presented at t+1.
- With `tx_ready` held high, a packet occupies `4 + len` consecutive cycles, followed by exactly one IDLE cycle before the next PREFIX.
- `tx_ready` low stalls with `tx_data` held and no `src_rdreq`.
- Simultaneous requests are served in cyclic order from `rr_ptr`. A source requesting continuously waits at most `N_SRC-1` packets.

## Configuration

- `PKT_ENCODER_CRC8_EN` undefined: the check byte is the mod-256 sum above.
- `PKT_ENCODER_CRC8_EN` defined: the check byte is CRC-8 over the same bytes in the same order.
  - Polynomial 0x07, initial value 0x00, MSB-first, no reflection, no final XOR.
  - Updated one byte per loaded byte; timing is unchanged.

## Test plan

- Single packet, sum mode: source 3, len 2, data 0x10, 0x20, `tx_ready` = 1. Expect A5, 03, 02, 10, 20, 35; `tx_last` on 35; two `src_rdreq[3]` pulses.
- Zero length: source 0, len 0. Expect A5, 00, 00, 00; no `src_rdreq`; `tx_last` on the fourth byte.
- Round-robin: sources 1, 5 and 9 valid continuously from reset. Expect packet order 1, 5, 9, 1, with one IDLE cycle between packets.
- Backpressure: `tx_ready` toggles every cycle during a len 4 packet. Expect each byte held until accepted, 4 pops total, and correct sum.
- Reset mid-DATA: assert `rst` after the second payload byte. Expect all outputs 0 next cycle, then a fresh packet from source 0 when it is valid.
- CRC mode (`PKT_ENCODER_CRC8_EN`): source 0, len 1, data 00. Expect check byte 0x15.

Source files
------------

// File: rtl/pkt_encoder.sv
// pkt_encoder: round-robin packet framer for the upstream link.
// Each packet is PREFIX, source id, length, payload, check byte, sent on a
// byte-wide valid/ready stream. The check byte is a mod-256 sum by default;
// define PKT_ENCODER_CRC8_EN to use CRC-8 (poly 0x07, init 0, MSB-first).
module pkt_encoder #(
  parameter int         N_SRC  = 38,
  parameter int         SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter logic [7:0] PREFIX = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_len,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_rdreq,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               tx_last,
  input  logic               tx_ready,
  output logic               busy,
  output logic [7:0]         cur_src
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFIX, S_SRC, S_LEN, S_DATA, S_CHK
  } state_t;

  state_t state, state_n;

  logic [SRC_W-1:0] g, g_n, rr_ptr, rr_n, grant;
  logic [7:0]       len_q, len_n, cnt, cnt_n, chk, chk_n;
  logic [7:0]       tx_data_n;
  logic             tx_valid_n, tx_last_n;
  logic             pop, accept, grant_any;
  logic [N_SRC-1:0] rot;
  int               off, pos;

  logic [N_SRC-1:0][7:0] len_arr, dat_arr;
  assign len_arr = src_len;
  assign dat_arr = src_data;

  assign accept  = tx_valid & tx_ready;
  assign busy    = (state != S_IDLE);
  assign cur_src = 8'(g);

  // Running check value folded with one more transmitted byte.
  function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
`ifdef PKT_ENCODER_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
`else
    return acc + b;
`endif
  endfunction

  // Cyclic priority search: rotate requests so rr_ptr sits at bit 0, take the
  // lowest set bit, then rotate the offset back into a source index.
  always_comb begin
    rot       = N_SRC'({src_valid, src_valid} >> rr_ptr);
    grant_any = |rot;
    off       = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pos = int'(rr_ptr) + off;
    if (pos >= N_SRC) pos = pos - N_SRC;
    grant = SRC_W'(pos);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and next-byte logic; every byte state loads its successor
  // on the same edge that the current byte is accepted.
  always_comb begin
    state_n    = state;
    g_n        = g;
    rr_n       = rr_ptr;
    len_n      = len_q;
    cnt_n      = cnt;
    chk_n      = chk;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    tx_last_n  = tx_last;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          g_n        = grant;
          len_n      = len_arr[grant];
          tx_data_n  = PREFIX;
          tx_valid_n = 1'b1;
          state_n    = S_PREFIX;
        end
      end
      S_PREFIX: begin
        if (accept) begin
          tx_data_n = 8'(g);
          chk_n     = chk_upd(8'h00, 8'(g));
          state_n   = S_SRC;
        end
      end
      S_SRC: begin
        if (accept) begin
          tx_data_n = len_q;
          chk_n     = chk_upd(chk, len_q);
          state_n   = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (len_q == 8'd0) begin
            tx_data_n = chk;
            tx_last_n = 1'b1;
            state_n   = S_CHK;
          end else begin
            tx_data_n = dat_arr[g];
            chk_n     = chk_upd(chk, dat_arr[g]);
            cnt_n     = 8'd1;
            pop       = 1'b1;
            state_n   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (cnt < len_q) begin
            tx_data_n = dat_arr[g];
            chk_n     = chk_upd(chk, dat_arr[g]);
            cnt_n     = cnt + 8'd1;
            pop       = 1'b1;
          end else begin
            tx_data_n = chk;
            tx_last_n = 1'b1;
            state_n   = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          tx_valid_n = 1'b0;
          tx_last_n  = 1'b0;
          cnt_n      = 8'd0;
          rr_n       = (int'(g) == N_SRC - 1) ? '0 : SRC_W'(int'(g) + 1);
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The FIFO pops on exactly the edges that consume its head byte.
    src_rdreq = pop ? (N_SRC'(1) << g) : '0;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      g        <= '0;
      rr_ptr   <= '0;
      len_q    <= 8'd0;
      cnt      <= 8'd0;
      chk      <= 8'd0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      g        <= g_n;
      rr_ptr   <= rr_n;
      len_q    <= len_n;
      cnt      <= cnt_n;
      chk      <= chk_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      tx_last  <= tx_last_n;
    end
  end

endmodule

// File: tb/tb_pkt_encoder.sv
// Scoreboard bench for pkt_encoder: a packet-level reference model predicts
// the byte stream per batch of queued messages; a monitor pops and compares.
module tb_pkt_encoder;
  localparam int         N   = 12;
  localparam logic [7:0] PFX = 8'hA5;

  logic             clk, rst;
  logic [N-1:0]     src_valid;
  logic [8*N-1:0]   src_len, src_data;
  logic [N-1:0]     src_rdreq;
  logic [7:0]       tx_data;
  logic             tx_valid, tx_last, tx_ready, busy;
  logic [7:0]       cur_src;

  pkt_encoder #(.N_SRC(N), .PREFIX(PFX)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_len(src_len),
    .src_data(src_data), .src_rdreq(src_rdreq), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .cur_src(cur_src)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       pay;
    logic       first;
    int         src;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo [N][$];   // environment: source FIFO contents
  int         elen [N][$];   // environment: pending message lengths
  logic [7:0] mdat [N][$];   // model copy of payloads
  int         mlen [N][$];   // model copy of lengths
  int         m_rr = 0;

  int npass = 0, ntotal = 0, cyc = 0, ready_mode = 3, last_cyc = 0, pkt_bytes = 0;
  bit chk_gap = 0, prev_last = 0, stall_pend = 0;
  logic [7:0]   held = 8'h00;
  logic [N-1:0] pend_pop = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(string name);
    ntotal++;
    $display("FAIL %s", name);
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      src_valid[i]      = (elen[i].size() > 0);
      src_len[8*i +: 8] = (elen[i].size() > 0) ? 8'(elen[i][0]) : 8'h00;
      src_data[8*i +: 8] = (fifo[i].size() > 0) ? fifo[i][0] : 8'h00;
    end
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) begin
      fifo[i].delete(); elen[i].delete(); mdat[i].delete(); mlen[i].delete();
    end
    drive_src();
  endtask

  function automatic logic [7:0] ref_check(int s, int len, logic [7:0] d[$]);
    int acc;
`ifdef PKT_ENCODER_CRC8_EN
    logic [7:0] bl[$];
    bl = {8'(s), 8'(len)};
    foreach (d[k]) bl.push_back(d[k]);
    acc = 0;
    foreach (bl[k]) begin
      acc = acc ^ int'(bl[k]);
      for (int b = 0; b < 8; b++)
        acc = (acc & 'h80) != 0 ? (((acc << 1) ^ 'h07) & 'hFF) : ((acc << 1) & 'hFF);
    end
`else
    acc = s + len;
    foreach (d[k]) acc += int'(d[k]);
    acc = acc % 256;
`endif
    return 8'(acc);
  endfunction

  task automatic add_msg(int s, int len, bit rnd);
    logic [7:0] b;
    elen[s].push_back(len);
    mlen[s].push_back(len);
    for (int k = 0; k < len; k++) begin
      b = rnd ? 8'($urandom) : 8'((k + 1) * 16);
      fifo[s].push_back(b);
      mdat[s].push_back(b);
    end
  endtask

  // Packet-level model: serve pending sources cyclically from m_rr.
  task automatic predict();
    int s, c, len;
    bit more;
    logic [7:0] d[$];
    more = 1;
    while (more) begin
      s = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (s < 0 && mlen[c].size() > 0) s = c;
      end
      if (s < 0) more = 0;
      else begin
        len = mlen[s].pop_front();
        d = {};
        for (int k = 0; k < len; k++) d.push_back(mdat[s].pop_front());
        exp_q.push_back('{PFX, 1'b0, 1'b0, 1'b1, s});
        exp_q.push_back('{8'(s), 1'b0, 1'b0, 1'b0, s});
        exp_q.push_back('{8'(len), 1'b0, 1'b0, 1'b0, s});
        foreach (d[k]) exp_q.push_back('{d[k], 1'b0, 1'b1, 1'b0, s});
        exp_q.push_back('{ref_check(s, len, d), 1'b1, 1'b0, 1'b0, s});
        m_rr = (s + 1) % N;
      end
    end
  endtask

  // Environment: apply FIFO pops seen last cycle, drive tx_ready.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend_pop[i]) begin
        if (fifo[i].size() > 0) fifo[i].delete(0);
        else fail_now("fifo_underflow");
      end
    end
    pend_pop = '0;
    drive_src();
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      2: tx_ready = ($urandom_range(0, 99) < 70);
      default: tx_ready = 1'b0;
    endcase
  end

  // Monitor: compare every accepted byte and the pop strobes.
  initial forever begin
    exp_t e;
    logic [N-1:0] exp_pop;
    @(negedge clk);
    if (rst) begin
      stall_pend = 0;
      pend_pop   = '0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(held));
      end
      stall_pend = tx_valid && !tx_ready;
      held       = tx_data;
      exp_pop    = '0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) fail_now("spurious_byte");
        else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("tx_last", 32'(tx_last), 32'(e.last));
          check("cur_src", 32'(cur_src), 32'(e.src));
          if (chk_gap) begin
            if (!e.first) check("byte_gap", 32'(cyc - last_cyc), 32'd1);
            else if (prev_last) check("pkt_gap", 32'(cyc - last_cyc), 32'd2);
          end
          last_cyc  = cyc;
          prev_last = e.last;
          if (exp_q.size() > 0 && exp_q[0].pay) exp_pop[exp_q[0].src] = 1'b1;
          if (e.last) begin
            if (elen[e.src].size() > 0) elen[e.src].delete(0);
            pkt_bytes = 0;
            drive_src();
          end else pkt_bytes++;
        end
      end
      check("src_rdreq", 32'(src_rdreq), 32'(exp_pop));
      pend_pop = src_rdreq;
    end
  end

  task automatic start_batch(int mode);
    @(posedge clk);
    #3;
    ready_mode = mode;
    chk_gap    = (mode == 0);
    prev_last  = 0;
  endtask

  task automatic go(int budget);
    int c, left;
    predict();
    drive_src();
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      clear_env();
    end
    repeat (3) @(posedge clk);
    #2;
    left = 0;
    for (int i = 0; i < N; i++) left += fifo[i].size() + elen[i].size();
    check("fifo_drained", 32'(left), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("valid_idle", 32'(tx_valid), 32'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_last), 32'd0);
    check("rst_rdreq", 32'(src_rdreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur_src", 32'(cur_src), 32'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    tx_ready = 1'b0;
    src_valid = '0; src_len = '0; src_data = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals();
    rst = 1'b0;

    // Single packet: expect A5 03 02 10 20 35.
    start_batch(0); add_msg(3, 2, 0); go(200);
    // Zero length from source 0.
    start_batch(0); add_msg(0, 0, 0); go(200);
    // Round-robin among 1, 5, 9 with two messages each.
    start_batch(0);
    for (int r = 0; r < 2; r++) begin
      add_msg(1, $urandom_range(0, 5), 1);
      add_msg(5, $urandom_range(0, 5), 1);
      add_msg(9, $urandom_range(0, 5), 1);
    end
    go(500);
    // Backpressure, ready toggling every cycle.
    start_batch(1); add_msg(7, 4, 1); go(200);
    // Maximum length packet.
    start_batch(0); add_msg(11, 255, 1); go(1000);

    // Randomised batches.
    for (int b = 0; b < 14; b++) begin
      start_batch(b % 3 == 0 ? 0 : (b % 3 == 1 ? 2 : 1));
      for (int m = $urandom_range(1, 6); m > 0; m--)
        add_msg($urandom_range(0, N - 1), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 16), 1);
      go(4000);
    end

    // Reset after the second payload byte.
    start_batch(0); add_msg(2, 6, 1); predict(); drive_src();
    c = 0;
    while (pkt_bytes < 5 && c < 500) begin
      @(posedge clk);
      c++;
    end
    if (pkt_bytes < 5) fail_now("reset_wait_timeout");
    ready_mode = 3;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_vals();
    exp_q.delete();
    clear_env();
    m_rr = 0;
    pkt_bytes = 0;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    // Fresh traffic: source 0 must win after reset.
    start_batch(0); add_msg(5, 3, 1); add_msg(0, 2, 1); go(500);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
